decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/register_file.sv | 32 +++
 rtl/decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode encodings, the NOP word and immediate helpers.
// The fetch and decode stages both import this package so that they agree
// on what a NOP is and which opcodes exist.
package decode_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENCODING = 32'h00000013;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpImm    = 7'b0010011,
        OpAuipc  = 7'b0010111,
        OpStore  = 7'b0100011,
        OpReg    = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJalr   = 7'b1100111,
        OpJal    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_type_e;

    // Immediate format selected by the opcode; unknown opcodes carry none.
    function automatic imm_type_e imm_type(input logic [6:0] op);
        imm_type_e t;
        t = ImmNone;
        case (op)
            OpLoad, OpImm, OpJalr: t = ImmI;
            OpStore:               t = ImmS;
            OpBranch:              t = ImmB;
            OpLui, OpAuipc:        t = ImmU;
            OpJal:                 t = ImmJ;
            default:               t = ImmNone;
        endcase
        return t;
    endfunction

    // Sign-extended immediate; only bits [31:7] of the word carry immediate data.
    function automatic logic [31:0] imm_value(input logic [31:7] ins, input imm_type_e t);
        logic [31:0] v;
        v = '0;
        case (t)
            ImmI: v = {{20{ins[31]}}, ins[31:20]};
            ImmS: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ImmB: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ImmU: v = {ins[31:12], 12'h000};
            ImmJ: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    // R-type has no immediate but is still a supported opcode.
    function automatic logic opcode_legal(input logic [6:0] op);
        return (imm_type(op) != ImmNone) || (op == OpReg);
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file.
//   i_clk, i_reset         clock, synchronous active-high reset (clears all entries)
//   i_raddr_a/b, o_rdata_a/b  two combinational read ports; x0 reads as zero
//   i_we, i_waddr, i_wdata    one synchronous write port; writes to x0 are dropped
module register_file (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [32];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'h0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'h0 : r_regs[i_raddr_b];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipeline decode register, field/immediate decode, register
// file read with write-back bypass, and JAL redirect to fetch.
//   clk, reset                       clock, synchronous active-high reset
//   instruction_in, pc_in, fetch_valid  word from fetch
//   stall, flush                     hold / discard the decode register
//   writeback_*                      register-file write port
//   decode_valid, pc_out, opcode, rd, funct3, funct7, rs1_data, rs2_data,
//   immediate, illegal_instruction   decoded outputs
//   branch_address(_enable)          JAL redirect, valid for one cycle
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTRUCTION         = 32'h00000013,
    parameter logic [31:0] INITIAL_PROGRAM_COUNTER = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        writeback_enable,
    input  logic [4:0]  writeback_register,
    input  logic [31:0] writeback_data,
    output logic        decode_valid,
    output logic [31:0] pc_out,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] immediate,
    output logic        illegal_instruction,
    output logic [31:0] branch_address,
    output logic        branch_address_enable
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_rf_rs1;
    logic [31:0] w_rf_rs2;
    logic [31:0] w_imm;
    logic        w_branch_en;

    // A taken JAL squashes the wrong-path word arriving on the next edge;
    // w_branch_en already excludes stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_INSTRUCTION;
            r_pc    <= INITIAL_PROGRAM_COUNTER;
            r_valid <= 1'b0;
        end else if (flush || w_branch_en) begin
            r_instr <= NOP_INSTRUCTION;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= instruction_in;
            r_pc    <= pc_in;
            r_valid <= fetch_valid;
        end
    end

    assign opcode = r_instr[6:0];
    assign rd     = r_instr[11:7];
    assign funct3 = r_instr[14:12];
    assign w_rs1  = r_instr[19:15];
    assign w_rs2  = r_instr[24:20];
    assign funct7 = r_instr[31:25];

    assign decode_valid = r_valid;
    assign pc_out       = r_pc;

    assign w_imm     = imm_value(r_instr[31:7], imm_type(r_instr[6:0]));
    assign immediate = w_imm;

    assign illegal_instruction = r_valid && !opcode_legal(r_instr[6:0]);

    register_file u_register_file (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_raddr_a (w_rs1),
        .i_raddr_b (w_rs2),
        .o_rdata_a (w_rf_rs1),
        .o_rdata_b (w_rf_rs2),
        .i_we      (writeback_enable),
        .i_waddr   (writeback_register),
        .i_wdata   (writeback_data)
    );

    // Same-cycle write-back forwarding; x0 is never forwarded.
    always_comb begin
        rs1_data = w_rf_rs1;
        rs2_data = w_rf_rs2;
        if (writeback_enable && (w_rs1 != 5'd0) && (writeback_register == w_rs1)) begin
            rs1_data = writeback_data;
        end
        if (writeback_enable && (w_rs2 != 5'd0) && (writeback_register == w_rs2)) begin
            rs2_data = writeback_data;
        end
    end

    assign w_branch_en = r_valid && (r_instr[6:0] == OpJal) && !stall && !flush;

    assign branch_address_enable = w_branch_en;
    assign branch_address        = w_branch_en ? (r_pc + w_imm) : 32'h0;

endmodule
